fetch_queue: RTL

Fetch stage of the pipelined RISC-V core, upstream of decode and the decode-stage control logic. Owns the fetch PC and issues word fetches to instruction memory over a request/grant/response handshake. Buffers returned instructions in a small prefetch FIFO and drives the IF/ID pipeline register that supplies InstrD, from which opD, funct3D and funct7b5D are taken. Accepts branch/jump redirects from the execute stage (PCSrcE, PCTargetE) and discards wrong-path fetches.

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, issues single-outstanding word fetches,
// buffers responses in a prefetch FIFO and drives the IF/ID register.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReqF,
  output logic [31:0] ImemAddrF,
  input  logic        ImemGntF,
  input  logic        ImemRvalidF,
  input  logic [31:0] ImemRdataF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  input  logic        FlushD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0]  pc_f;
  logic [XLEN-1:0]  req_pc;
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             outstanding;
  logic             drop;

  logic fire;
  logic rsp;
  logic push;
  logic pop;
  logic has_space;

  // Space check counts the in-flight request so a response always has a slot.
  assign has_space = (SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(DEPTH);
  assign ImemReqF  = reset & ~outstanding & has_space & ~PCSrcE;
  assign ImemAddrF = pc_f;

  assign fire = ImemReqF & ImemGntF;
  assign rsp  = ImemRvalidF & outstanding;
  assign push = rsp & ~drop & ~PCSrcE;
  assign pop  = ~PCSrcE & ~FlushD & ~StallD & (count != '0);

  // Fetch PC, request tracking and FIFO bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f        <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      if (rsp)       outstanding <= 1'b0;
      else if (fire) outstanding <= 1'b1;

      if (PCSrcE) begin
        pc_f   <= PCTargetE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        drop   <= outstanding & ~ImemRvalidF;
      end else begin
        if (fire) begin
          pc_f   <= pc_f + 32'd4;
          req_pc <= pc_f;
        end
        if (rsp && drop) drop <= 1'b0;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= req_pc;
      instr_mem[wr_ptr] <= ImemRdataF;
    end
  end

  // IF/ID register: redirect/flush bubble beats stall, stall beats pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (PCSrcE || FlushD) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (count != '0) begin
        InstrD   <= instr_mem[rd_ptr];
        PCD      <= pc_mem[rd_ptr];
        PCPlus4D <= pc_mem[rd_ptr] + 32'd4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP;
        ValidD <= 1'b0;
      end
    end
  end

endmodule
